logic_issue_ctrl: RTL

Issue/capture controller sitting directly upstream of the processor's registered 16-bit logical units. It accepts logical-operation requests over a valid/ready handshake, drives stable operands and an operation code into the logic unit for its one-cycle registered latency, captures the unit's result, and attaches zero/negative/error flags. It then presents the result downstream to writeback over a second valid/ready handshake.

---
 rtl/logic_issue_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/logic_issue_ctrl.sv
// Issue/capture controller for the registered 16-bit logic unit: accepts requests,
// holds operands across the unit's latency, captures and flags the result for writeback.
module logic_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [2:0]  lu_op,
    output logic [15:0] lu_inp1,
    output logic [15:0] lu_inp2,
    input  logic [15:0] lu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_lu_op;
    logic [15:0] r_lu_inp1;
    logic [15:0] r_lu_inp2;
    logic [15:0] r_result;
    logic [15:0] r_count;
    logic        r_valid;
    logic        r_zero;
    logic        r_neg;
    logic        r_err;

    logic        w_ready;
    logic        w_accept;
    logic        w_legal;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // In DONE a new request may ride on the same edge as the result transfer.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            w_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        end
    end

    assign w_accept = in_valid & w_ready;
    assign w_legal  = op_legal(in_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lu_op   <= 3'd0;
            r_lu_inp1 <= 16'd0;
            r_lu_inp2 <= 16'd0;
            r_result  <= 16'd0;
            r_count   <= 16'd0;
            r_valid   <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_valid && out_ready) begin
                r_count <= r_count + 16'd1;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_lu_op   <= in_op;
                    r_lu_inp1 <= in_a;
                    r_lu_inp2 <= in_b;
                    r_valid   <= 1'b0;
                    r_state   <= WAIT1;
                end else begin
                    // Illegal opcodes never reach the unit; answer directly with an error.
                    r_result  <= 16'd0;
                    r_zero    <= 1'b1;
                    r_neg     <= 1'b0;
                    r_err     <= 1'b1;
                    r_valid   <= 1'b1;
                    r_state   <= DONE;
                end
            end else begin
                case (r_state)
                    WAIT1: r_state <= WAIT2;
                    WAIT2: begin
                        r_result <= lu_out;
                        r_zero   <= (lu_out == 16'd0);
                        r_neg    <= lu_out[15];
                        r_err    <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                    DONE: begin
                        if (out_ready) begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign lu_op      = r_lu_op;
    assign lu_inp1    = r_lu_inp1;
    assign lu_inp2    = r_lu_inp2;
    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_neg    = r_neg;
    assign out_err    = r_err;
    assign op_count   = r_count;

endmodule
